// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Exhaustive response checker for a pair of combinational DUT outputs. It sweeps every
//   input vector 0..2^N_IN-1 and holds each one for SETTLE+1 cycles. At the last cycle of
//   each vector it samples resp_a and resp_b and checks them against the golden table
//   EXPECTED and against each other. It then reports the failure count, the lowest failing
//   vector and an overall pass flag.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous, active-high reset
//   start       in   1       begin a sweep; honoured only when idle or done
//   resp_a      in   1       DUT output A (reference form)
//   resp_b      in   1       DUT output B (minimized form)
//   vec         out  N_IN    vector driven to the DUT inputs, MSB first
//   busy        out  1       sweep in progress
//   done        out  1       sweep finished; held until start or rst
//   pass        out  1       done with no failures
//   err_count   out  N_IN+1  number of failing vectors
//   fail_valid  out  1       at least one failure recorded
//   first_fail  out  N_IN    lowest failing vector; 0 when fail_valid is low

module truth_table_checker #(
  parameter int unsigned            N_IN     = 5,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = '0,
  parameter int unsigned            SETTLE   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            resp_a,
  input  logic            resp_b,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  localparam int unsigned    CntW      = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] SettleVal = CntW'(SETTLE);
  localparam logic [N_IN-1:0] LastVec   = {N_IN{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            vec_fail;

  // Only meaningful at the sample edge; resp_* may be X before then.
  assign vec_fail = (resp_a != EXPECTED[vec_q]) || (resp_b != resp_a);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SettleVal) begin
          if (vec_fail) begin
            err_d = err_q + 1'b1;
            // Vectors are swept in ascending order, so the first recorded is the lowest.
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = vec_q;
            end
          end
          cnt_d = '0;
          if (vec_q == LastVec) begin
            state_d = StDone;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign pass       = (state_q == StDone) && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule
